// File: rtl/reg_file_sb.sv
`default_nettype none
// ============================================================================
// Module      : reg_file_sb
// Description : Two-read / one-write register file with a per-register busy
//               scoreboard and registered busy count. Optional same-cycle
//               write-to-read bypass is enabled by defining RF_BYPASS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module reg_file_sb #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wren,
    input  logic [ADDR_W-1:0] wr,
    input  logic [DATA_W-1:0] wd,
    input  logic [ADDR_W-1:0] rr1,
    input  logic [ADDR_W-1:0] rr2,
    output logic [DATA_W-1:0] rd1,
    output logic [DATA_W-1:0] rd2,
    input  logic              iss_valid,
    input  logic [ADDR_W-1:0] iss_rd,
    output logic              busy1,
    output logic              busy2,
    output logic [ADDR_W:0]   busy_cnt
);

    localparam int   C_DEPTH = 2**ADDR_W;
    localparam int   C_CNT_W = ADDR_W + 1;
    localparam logic C_ZERO  = (ZERO_REG != 0);

    logic [DATA_W-1:0]  regs_q [C_DEPTH];
    logic [C_DEPTH-1:0] busy_q;
    logic [C_DEPTH-1:0] busy_d;
    logic [C_CNT_W-1:0] busy_cnt_q;
    logic [C_CNT_W-1:0] busy_cnt_d;

    logic              w_wr_en;
    logic              w_set_en;
    logic              w_inc;
    logic              w_dec;
    logic [DATA_W-1:0] w_rd1_store;
    logic [DATA_W-1:0] w_rd2_store;

    assign w_wr_en  = wren && !(C_ZERO && (wr == '0));
    assign w_set_en = iss_valid && !(C_ZERO && (iss_rd == '0));

    // Set is applied after clear so a same-index collision leaves the bit set.
    always_comb begin
        busy_d = busy_q;
        if (w_wr_en) begin
            busy_d[wr] = 1'b0;
        end
        if (w_set_en) begin
            busy_d[iss_rd] = 1'b1;
        end
    end

    assign w_inc      = w_set_en && !busy_q[iss_rd];
    assign w_dec      = w_wr_en && busy_q[wr] && !(w_set_en && (iss_rd == wr));
    assign busy_cnt_d = busy_cnt_q + C_CNT_W'(w_inc) - C_CNT_W'(w_dec);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < C_DEPTH; i++) begin
                regs_q[i] <= '0;
            end
            busy_q     <= '0;
            busy_cnt_q <= '0;
        end else begin
            if (w_wr_en) begin
                regs_q[wr] <= wd;
            end
            busy_q     <= busy_d;
            busy_cnt_q <= busy_cnt_d;
        end
    end

    assign w_rd1_store = (C_ZERO && (rr1 == '0)) ? '0 : regs_q[rr1];
    assign w_rd2_store = (C_ZERO && (rr2 == '0)) ? '0 : regs_q[rr2];
    assign busy_cnt    = busy_cnt_q;

`ifdef RF_BYPASS_EN
    logic w_byp1;
    logic w_byp2;
    logic w_iss1;
    logic w_iss2;

    // Bypass is gated by rst_n so reads stay zero throughout reset.
    assign w_byp1 = rst_n && w_wr_en && (wr == rr1);
    assign w_byp2 = rst_n && w_wr_en && (wr == rr2);
    assign w_iss1 = rst_n && w_set_en && (iss_rd == rr1);
    assign w_iss2 = rst_n && w_set_en && (iss_rd == rr2);

    assign rd1   = w_byp1 ? wd     : w_rd1_store;
    assign rd2   = w_byp2 ? wd     : w_rd2_store;
    assign busy1 = w_byp1 ? w_iss1 : busy_q[rr1];
    assign busy2 = w_byp2 ? w_iss2 : busy_q[rr2];
`else
    assign rd1   = w_rd1_store;
    assign rd2   = w_rd2_store;
    assign busy1 = busy_q[rr1];
    assign busy2 = busy_q[rr2];
`endif

endmodule
`default_nettype wire
